fnd_time_scan: RTL

- Display stage directly downstream of the 0..59 seconds counter and its NCO-driven tick chain.
- Takes two 6-bit time fields (e.g. minutes and seconds) and filters them into the fast clk domain.
- Converts each field to two BCD digits and drives a 4-digit, time-multiplexed, common-anode 7-segment display.
- Adds anti-ghosting blanking between digit switches.

---
 rtl/fnd_time_scan_if.sv | 12 +
 rtl/fnd_time_scan.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fnd_time_scan_if.sv
// Time-field inputs and multiplexed 7-segment outputs of fnd_time_scan.
// The master modport drives the time fields; the slave modport is the display stage.
interface fnd_time_scan_if;
    logic [5:0] val_hi;
    logic [5:0] val_lo;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (output val_hi, output val_lo, input seg, input dp, input an);
    modport slave  (input val_hi, input val_lo, output seg, output dp, output an);
endinterface

// File: rtl/fnd_time_scan.sv
// Filters two 0..59 time fields and scans them onto a 4-digit common-anode
// 7-segment display. Optional macro FND_LZB_EN blanks a tens digit that is zero.
module fnd_time_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fnd_time_scan_if.slave  bus
);
    localparam int             CW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYC);
    localparam logic [3:0]     CODE_DASH  = 4'hA;
    localparam logic [3:0]     CODE_BLANK = 4'hF;

    logic [5:0]    q1_hi, q1_lo, q2_hi, q2_lo;
    logic [5:0]    held_hi, held_lo;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [7:0]    bcd_hi, bcd_lo;
    logic [3:0]    digit_val;
    logic          blank;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;

    // Two-stage capture; held only follows a value seen on two consecutive edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_hi   <= '0;
            q1_lo   <= '0;
            q2_hi   <= '0;
            q2_lo   <= '0;
            held_hi <= '0;
            held_lo <= '0;
        end else begin
            q1_hi <= bus.val_hi;
            q1_lo <= bus.val_lo;
            q2_hi <= q1_hi;
            q2_lo <= q1_lo;
            if (q1_hi == q2_hi) held_hi <= q2_hi;
            if (q1_lo == q2_lo) held_lo <= q2_lo;
        end
    end

    // Returns {tens, ones} as internal digit codes; out-of-range shows dashes.
    function automatic logic [7:0] to_bcd(input logic [5:0] h);
        if (h >= 6'd60) return {CODE_DASH, CODE_DASH};
        return {4'(h / 6'd10), 4'(h % 6'd10)};
    endfunction

    function automatic logic [3:0] tens_code(input logic [3:0] t);
`ifdef FND_LZB_EN
        return (t == 4'd0) ? CODE_BLANK : t;
`else
        return t;
`endif
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hA:    return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    assign bcd_hi = to_bcd(held_hi);
    assign bcd_lo = to_bcd(held_lo);
    assign blank  = (scan_cnt < BLANK_LAST);

    always_comb begin
        digit_val = CODE_BLANK;
        case (digit_idx)
            2'd0: digit_val = bcd_lo[3:0];
            2'd1: digit_val = tens_code(bcd_lo[7:4]);
            2'd2: digit_val = bcd_hi[3:0];
            2'd3: digit_val = tens_code(bcd_hi[7:4]);
            default: digit_val = CODE_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // Registered drive; the first BLANK_CYC cycles of each slot are dark to suppress ghosting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg  <= 4'b1111;
            seg_reg <= 7'h7F;
            dp_reg  <= 1'b1;
        end else if (blank) begin
            an_reg  <= 4'b1111;
            seg_reg <= 7'h7F;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= ~(4'b0001 << digit_idx);
            seg_reg <= seg_code(digit_val);
            dp_reg  <= (digit_idx != 2'd2);
        end
    end

    assign bus.an  = an_reg;
    assign bus.seg = seg_reg;
    assign bus.dp  = dp_reg;
endmodule
